// File: rtl/exec_stage_mc.sv
// Execute stage: operand forwarding, single-cycle ALU, destination mux and an iterative
// shift-add multiplier that stalls the front end. Optional MULH high-half result: EXEC_MULH_EN.
module exec_stage_mc #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             REG_WRITE_E,
  input  logic             MEM_TO_REG_E,
  input  logic             MEM_WRITE_E,
  input  logic [3:0]       ALU_CONTROL_E,
  input  logic             ALU_SRC_E,
  input  logic             REG_DST_E,
  input  logic [WIDTH-1:0] RD1_E,
  input  logic [WIDTH-1:0] RD2_E,
  input  logic [4:0]       RA2_E,
  input  logic [4:0]       RS_E,
  input  logic [WIDTH-1:0] SIGN_IMM_E,
  input  logic [1:0]       FWD_A_E,
  input  logic [1:0]       FWD_B_E,
  input  logic [WIDTH-1:0] ALU_OUT_M,
  input  logic [WIDTH-1:0] RESULT_W,
  output logic [WIDTH-1:0] ALU_OUT_E,
  output logic [WIDTH-1:0] WRITE_DATA_E,
  output logic [4:0]       WRITE_REG_E,
  output logic             STALL_E,
  output logic             REG_WRITE_EO,
  output logic             MEM_TO_REG_EO,
  output logic             MEM_WRITE_EO
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_MULH = 4'b1001;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

  mul_state_t             state, state_nxt;
  logic [2*WIDTH-1:0]     product;
  logic [WIDTH-1:0]       mcand;
  logic [WIDTH-1:0]       mplier;
  logic [CW-1:0]          cnt;
  logic [WIDTH-1:0]       src_a, fwd_b, src_b;
  logic signed [WIDTH-1:0] s_a, s_b;
  logic [WIDTH:0]         acc_sum;
  logic                   is_mul;
  logic [WIDTH-1:0]       alu_res;

  function automatic logic [WIDTH-1:0] fwd_pick(input logic [1:0] sel,
                                                input logic [WIDTH-1:0] rd,
                                                input logic [WIDTH-1:0] m,
                                                input logic [WIDTH-1:0] w);
    case (sel)
      2'b01:   return w;
      2'b10:   return m;
      default: return rd;
    endcase
  endfunction

  assign src_a = fwd_pick(FWD_A_E, RD1_E, ALU_OUT_M, RESULT_W);
  assign fwd_b = fwd_pick(FWD_B_E, RD2_E, ALU_OUT_M, RESULT_W);
  assign src_b = ALU_SRC_E ? SIGN_IMM_E : fwd_b;
  assign s_a   = src_a;
  assign s_b   = src_b;

`ifdef EXEC_MULH_EN
  assign is_mul = (ALU_CONTROL_E == OP_MUL) || (ALU_CONTROL_E == OP_MULH);
`else
  assign is_mul = (ALU_CONTROL_E == OP_MUL);
`endif

  assign STALL_E       = is_mul && (state != DONE) && !CLR;
  assign REG_WRITE_EO  = REG_WRITE_E & ~STALL_E;
  assign MEM_WRITE_EO  = MEM_WRITE_E & ~STALL_E;
  assign MEM_TO_REG_EO = MEM_TO_REG_E;
  assign WRITE_DATA_E  = fwd_b;
  assign WRITE_REG_E   = REG_DST_E ? RS_E : RA2_E;

  always_comb begin
    alu_res = '0;
    case (ALU_CONTROL_E)
      OP_ADD: alu_res = src_a + src_b;
      OP_SUB: alu_res = src_a - src_b;
      OP_AND: alu_res = src_a & src_b;
      OP_OR:  alu_res = src_a | src_b;
      OP_XOR: alu_res = src_a ^ src_b;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, (s_a < s_b)};
      OP_SLL: alu_res = src_a << src_b[4:0];
      OP_SRL: alu_res = src_a >> src_b[4:0];
      OP_MUL: alu_res = (state == DONE) ? product[WIDTH-1:0] : '0;
`ifdef EXEC_MULH_EN
      OP_MULH: alu_res = (state == DONE) ? product[2*WIDTH-1:WIDTH] : '0;
`endif
      default: alu_res = '0;
    endcase
  end

  assign ALU_OUT_E = alu_res;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (is_mul) state_nxt = BUSY;
      BUSY:    if (cnt == CW'(WIDTH-1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(negedge CLK or posedge CLR) begin
    if (CLR) state <= IDLE;
    else     state <= state_nxt;
  end

  // The product shifts right each iteration so the multiplicand is always added to the upper half
  assign acc_sum = {1'b0, product[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};

  always_ff @(negedge CLK or posedge CLR) begin
    if (CLR) begin
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else if (state == IDLE && is_mul) begin
      product <= '0;
      mcand   <= src_a;
      mplier  <= src_b;
      cnt     <= '0;
    end else if (state == BUSY) begin
      product <= {acc_sum, product[WIDTH-1:1]};
      mplier  <= mplier >> 1;
      cnt     <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_exec_stage_mc.sv
// Self-checking bench for exec_stage_mc: directed and randomized steps against a behavioural model.
module tb_exec_stage_mc;
  localparam int W = 32;

  logic CLK = 1'b0, CLR = 1'b0;
  logic REG_WRITE_E = 0, MEM_TO_REG_E = 0, MEM_WRITE_E = 0;
  logic [3:0] ALU_CONTROL_E = 4'hF;
  logic ALU_SRC_E = 0, REG_DST_E = 0;
  logic [W-1:0] RD1_E = 0, RD2_E = 0, SIGN_IMM_E = 0, ALU_OUT_M = 0, RESULT_W = 0;
  logic [4:0] RA2_E = 0, RS_E = 0;
  logic [1:0] FWD_A_E = 0, FWD_B_E = 0;
  logic [W-1:0] ALU_OUT_E, WRITE_DATA_E;
  logic [4:0] WRITE_REG_E;
  logic STALL_E, REG_WRITE_EO, MEM_TO_REG_EO, MEM_WRITE_EO;

  int checks = 0;
  int errors = 0;

  exec_stage_mc #(.WIDTH(W)) dut (
    .CLK(CLK), .CLR(CLR), .REG_WRITE_E(REG_WRITE_E), .MEM_TO_REG_E(MEM_TO_REG_E),
    .MEM_WRITE_E(MEM_WRITE_E), .ALU_CONTROL_E(ALU_CONTROL_E), .ALU_SRC_E(ALU_SRC_E),
    .REG_DST_E(REG_DST_E), .RD1_E(RD1_E), .RD2_E(RD2_E), .RA2_E(RA2_E), .RS_E(RS_E),
    .SIGN_IMM_E(SIGN_IMM_E), .FWD_A_E(FWD_A_E), .FWD_B_E(FWD_B_E), .ALU_OUT_M(ALU_OUT_M),
    .RESULT_W(RESULT_W), .ALU_OUT_E(ALU_OUT_E), .WRITE_DATA_E(WRITE_DATA_E),
    .WRITE_REG_E(WRITE_REG_E), .STALL_E(STALL_E), .REG_WRITE_EO(REG_WRITE_EO),
    .MEM_TO_REG_EO(MEM_TO_REG_EO), .MEM_WRITE_EO(MEM_WRITE_EO)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge,
  // well clear of the falling edge that updates state.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [W-1:0] m_fwd(input logic [1:0] sel, input logic [W-1:0] rd);
    if (sel == 2'b01) return RESULT_W;
    if (sel == 2'b10) return ALU_OUT_M;
    return rd;
  endfunction

  function automatic logic [W-1:0] m_srca();
    return m_fwd(FWD_A_E, RD1_E);
  endfunction

  function automatic logic [W-1:0] m_srcb();
    return ALU_SRC_E ? SIGN_IMM_E : m_fwd(FWD_B_E, RD2_E);
  endfunction

  function automatic logic [W-1:0] m_alu(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return (sa < sb) ? 1 : 0;
      4'd6: return a << (b % 32);
      4'd7: return a >> (b % 32);
      default: return 0;
    endcase
  endfunction

  function automatic logic [W-1:0] m_mul_lo(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return p[W-1:0];
  endfunction

  task automatic set_nop();
    ALU_CONTROL_E = 4'hF; REG_WRITE_E = 0; MEM_WRITE_E = 0; MEM_TO_REG_E = 0;
    FWD_A_E = 0; FWD_B_E = 0; ALU_SRC_E = 0; REG_DST_E = 0;
    RD1_E = 0; RD2_E = 0; SIGN_IMM_E = 0; ALU_OUT_M = 0; RESULT_W = 0;
  endtask

  // Starts from an IDLE cycle with MUL applied; returns in the DONE cycle without advancing.
  task automatic run_mul(input string tag, input logic [W-1:0] exp, input bit scramble);
    int  n;
    bit  ctl_bad;
    n = 0;
    ctl_bad = 0;
    #1;
    while (STALL_E === 1'b1 && n < 200) begin
      if (REG_WRITE_EO !== 1'b0 || MEM_WRITE_EO !== 1'b0) ctl_bad = 1;
      n++;
      step();
      if (scramble) begin
        RD1_E = $urandom; RD2_E = $urandom; ALU_OUT_M = $urandom;
        RESULT_W = $urandom; SIGN_IMM_E = $urandom;
        #1;
      end
    end
    chk({tag, "_stall_edges"}, n, W + 1);
    chk({tag, "_ctl_gated"}, {31'b0, ctl_bad}, 0);
    chk({tag, "_done_nostall"}, {31'b0, STALL_E}, 0);
    chk({tag, "_done_rw"}, {31'b0, REG_WRITE_EO}, {31'b0, REG_WRITE_E});
    chk({tag, "_product"}, ALU_OUT_E, exp);
  endtask

  initial begin
    logic [3:0] ops [15];
    logic [W-1:0] a, b, exp;
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'hF, 4'hA, 4'hB, 4'hC,
            4'hD, 4'hE, 4'd5};
`ifndef EXEC_MULH_EN
    ops[14] = 4'h9;
`endif

    // Reset
    set_nop();
    @(posedge CLK); #1;
    CLR = 1;
    step();
    chk("rst_stall", {31'b0, STALL_E}, 0);
    chk("rst_alu", ALU_OUT_E, 0);
    CLR = 0;
    step();
    chk("rst_rel_stall", {31'b0, STALL_E}, 0);

    // ADD with forwarding
    ALU_CONTROL_E = 4'd0; RD1_E = 5; FWD_A_E = 2'b10; ALU_OUT_M = 7;
    ALU_SRC_E = 1; SIGN_IMM_E = 3; REG_WRITE_E = 1; #1;
    chk("add_fwd_m", ALU_OUT_E, 10);
    FWD_A_E = 2'b01; RESULT_W = 20; #1;
    chk("add_fwd_w", ALU_OUT_E, 23);
    FWD_A_E = 2'b11; #1;
    chk("add_fwd_11", ALU_OUT_E, 8);

    // SLT signed and SLL amount masking
    ALU_CONTROL_E = 4'd5; FWD_A_E = 0; RD1_E = 32'hFFFF_FFFF; SIGN_IMM_E = 1; #1;
    chk("slt_neg", ALU_OUT_E, 1);
    RD1_E = 1; SIGN_IMM_E = 32'hFFFF_FFFF; #1;
    chk("slt_swap", ALU_OUT_E, 0);
    ALU_CONTROL_E = 4'd6; RD1_E = 1; SIGN_IMM_E = 32'h24; #1;
    chk("sll_mask", ALU_OUT_E, 32'h10);
    ALU_CONTROL_E = 4'd1; RD1_E = 0; SIGN_IMM_E = 1; #1;
    chk("sub_wrap", ALU_OUT_E, 32'hFFFF_FFFF);

    // Destination and store-data muxes
    REG_DST_E = 1; RS_E = 9; RA2_E = 3; #1;
    chk("dst_rs", {27'b0, WRITE_REG_E}, 9);
    REG_DST_E = 0; #1;
    chk("dst_ra2", {27'b0, WRITE_REG_E}, 3);
    FWD_B_E = 2'b10; ALU_SRC_E = 1; ALU_OUT_M = 32'hCAFE_0001; RD2_E = 32'h1111; #1;
    chk("wdata_fwd_m", WRITE_DATA_E, 32'hCAFE_0001);

`ifndef EXEC_MULH_EN
    ALU_CONTROL_E = 4'h9; #1;
    chk("op9_zero", ALU_OUT_E, 0);
    chk("op9_nostall", {31'b0, STALL_E}, 0);
`endif

    // Randomized single-cycle ops
    for (int i = 0; i < 40; i++) begin
      ALU_CONTROL_E = ops[$urandom_range(0, 14)];
      FWD_A_E = $urandom; FWD_B_E = $urandom; ALU_SRC_E = $urandom; REG_DST_E = $urandom;
      RD1_E = $urandom; RD2_E = $urandom; ALU_OUT_M = $urandom; RESULT_W = $urandom;
      SIGN_IMM_E = (i % 3 == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
      RA2_E = $urandom; RS_E = $urandom;
      REG_WRITE_E = $urandom; MEM_WRITE_E = $urandom; MEM_TO_REG_E = $urandom;
      #1;
      chk("rnd_alu", ALU_OUT_E, m_alu(ALU_CONTROL_E, m_srca(), m_srcb()));
      chk("rnd_wdata", WRITE_DATA_E, m_fwd(FWD_B_E, RD2_E));
      chk("rnd_wreg", {27'b0, WRITE_REG_E}, {27'b0, REG_DST_E ? RS_E : RA2_E});
      chk("rnd_ctl", {29'b0, REG_WRITE_EO, MEM_WRITE_EO, MEM_TO_REG_EO},
          {29'b0, REG_WRITE_E, MEM_WRITE_E, MEM_TO_REG_E});
      chk("rnd_nostall", {31'b0, STALL_E}, 0);
      step();
    end

    // Directed MUL
    set_nop();
    ALU_CONTROL_E = 4'd8; RD1_E = 32'h1234; RD2_E = 32'h10; REG_WRITE_E = 1; MEM_WRITE_E = 1;
    run_mul("mul_dir", 32'h0001_2340, 1'b0);
    ALU_CONTROL_E = 4'hF;
    step();

    // Random MULs with forwarded operands scrambled after latch, then back-to-back
    for (int k = 0; k < 3; k++) begin
      FWD_A_E = $urandom; FWD_B_E = $urandom; ALU_SRC_E = $urandom;
      RD1_E = $urandom; RD2_E = $urandom; ALU_OUT_M = $urandom;
      RESULT_W = $urandom; SIGN_IMM_E = $urandom;
      ALU_CONTROL_E = 4'd8; #1;
      exp = m_mul_lo(m_srca(), m_srcb());
      run_mul("mul_rnd", exp, 1'b1);
      if (k == 2) ALU_CONTROL_E = 4'hF;
      step();
    end
    chk("mul_after_idle", {31'b0, STALL_E}, 0);

    // Flush during BUSY: stall drops at once, ALU follows the new op
    ALU_CONTROL_E = 4'd8; FWD_A_E = 0; FWD_B_E = 0; ALU_SRC_E = 0;
    RD1_E = 32'd77; RD2_E = 32'd3; #1;
    for (int j = 0; j < 5; j++) step();
    ALU_CONTROL_E = 4'd0; #1;
    chk("flush_nostall", {31'b0, STALL_E}, 0);
    chk("flush_alu", ALU_OUT_E, 32'd80);
    chk("flush_rw", {31'b0, REG_WRITE_EO}, 1);
    for (int j = 0; j < 40; j++) step();

    // CLR in the middle of BUSY, MUL stays applied and restarts
    a = $urandom; b = $urandom;
    ALU_CONTROL_E = 4'd8; RD1_E = a; RD2_E = b; #1;
    for (int j = 0; j < 11; j++) step();
    chk("clr_pre_stall", {31'b0, STALL_E}, 1);
    #1 CLR = 1; #1;
    chk("clr_stall", {31'b0, STALL_E}, 0);
    chk("clr_rw", {31'b0, REG_WRITE_EO}, 1);
    step();
    chk("clr_hold_stall", {31'b0, STALL_E}, 0);
    CLR = 0;
    run_mul("mul_clr", m_mul_lo(a, b), 1'b0);
    ALU_CONTROL_E = 4'hF;
    step();

`ifdef EXEC_MULH_EN
    ALU_CONTROL_E = 4'h9; RD1_E = 32'h8000_0000; RD2_E = 32'h6; #1;
    run_mul("mulh", 32'h3, 1'b0);
    ALU_CONTROL_E = 4'hF;
    step();
`endif

    set_nop(); #1;
    chk("end_nop_alu", ALU_OUT_E, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
